mem_req_ctrl: RTL and testbench

Request front-end for the 1024x32 byte-enabled single-port SRAM model. It accepts read/write requests from a host over a valid/ready handshake and drives the SRAM address, read/write-select, write-data and byte-enable ports. It captures the SRAM's one-cycle registered read data and returns it to the host through an in-order response FIFO with backpressure. It sits directly upstream of the SRAM and owns all SRAM port timing.

---
 rtl/mem_req_ctrl.sv | 102 ++++++++++
 tb/tb_mem_req_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// Host request front-end for a byte-enabled single-port SRAM with a registered read port.
// Read data is returned through an in-order response FIFO; request credit keeps that FIFO from overflowing.
module mem_req_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_re_web,
  output logic [DATA_W-1:0]     mem_write_data,
  output logic [DATA_W/8-1:0]   mem_byte_en,
  input  logic [DATA_W-1:0]     mem_read_data
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

  logic                s1_q, s1_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   fifo_q [RSP_DEPTH];
  logic [DATA_W-1:0]   fifo_d [RSP_DEPTH];
  logic                accept;
  logic                push;
  logic                pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // Credit counts the in-flight read as occupied, so a pop only frees space a cycle later.
  always_comb begin
    req_ready      = !reset && (({1'b0, count_q} + {{CNT_W{1'b0}}, s1_q}) < DEPTH_C);
    accept         = req_valid && req_ready;
    mem_addr       = req_addr;
    mem_write_data = req_wdata;
    mem_byte_en    = req_be;
    mem_re_web     = !(accept && req_write);
    push           = s1_q;
    pop            = (count_q != '0) && rsp_ready;
    s1_d           = accept && !req_write;
    fifo_d         = fifo_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = mem_read_data;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q     <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      s1_q     <= s1_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fifo_q   <= fifo_d;
    end
  end

  assign rsp_valid = (count_q != '0);
  assign rsp_rdata = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: behavioural SRAM, transaction-level reference model of
// credit, latency and in-order responses, directed steps followed by random traffic.
module tb_mem_req_ctrl;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_re_web;
  logic [DW-1:0] mem_write_data;
  logic [BW-1:0] mem_byte_en;
  logic [DW-1:0] mem_read_data;

  always #5 clock = ~clock;

  mem_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_re_web(mem_re_web), .mem_write_data(mem_write_data),
    .mem_byte_en(mem_byte_en), .mem_read_data(mem_read_data)
  );

  // SRAM: byte-merged write, one-cycle registered read
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (!mem_re_web) begin
      for (int b = 0; b < BW; b++) begin
        if (mem_byte_en[b]) sram[mem_addr][8*b +: 8] <= mem_write_data[8*b +: 8];
      end
    end else begin
      mem_read_data <= sram[mem_addr];
    end
  end

  // Reference model
  typedef struct { logic [DW-1:0] d; int c; } rsp_t;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  rsp_t          q[$];
  int            cyc = 0, outstanding = 0, dut_out = 0;
  int            n_acc = 0, n_pop = 0, wr_low = 0;
  int            checks = 0, errors = 0;
  logic [DW-1:0] last_pop;
  logic          last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic set_req(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_be = be;
  endtask

  // One clock: check outputs at negedge, then advance the model at posedge.
  task automatic cycle();
    logic exp_ready, exp_valid, acc, pop, d_acc, d_pop;
    @(negedge clock);
    exp_ready = !reset && (outstanding < DEPTH);
    exp_valid = (q.size() > 0) && (q[0].c <= cyc - 2);
    chk("req_ready", req_ready, exp_ready);
    chk("rsp_valid", rsp_valid, exp_valid);
    if (exp_valid) chk("rsp_rdata", rsp_rdata, q[0].d);
    chk("mem_re_web", mem_re_web, !(req_valid && exp_ready && req_write));
    chk("mem_addr", mem_addr, req_addr);
    if (mem_re_web === 1'b0) wr_low++;
    acc = req_valid && exp_ready;
    pop = exp_valid && rsp_ready;
    d_acc = req_valid && req_ready && !req_write;
    d_pop = rsp_valid && rsp_ready;
    last_acc = acc;
    @(posedge clock);
    if (reset) begin
      q.delete(); outstanding = 0; dut_out = 0;
    end else begin
      dut_out = dut_out + int'(d_acc) - int'(d_pop);
      if (pop) begin
        last_pop = q[0].d; void'(q.pop_front()); outstanding--; n_pop++;
      end
      if (acc && req_write) begin
        ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_be);
      end else if (acc) begin
        q.push_back('{d: ref_mem[req_addr], c: cyc}); outstanding++; n_acc++;
      end
    end
    chk("fifo_no_overflow", 32'(dut_out <= DEPTH), 32'd1);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int base_acc, base_pop, base_wr, i;
    logic [AW-1:0] ra [3];
    reset = 1'b1; rsp_ready = 1'b1;
    set_req(1'b0, 1'b0, '0, '0, '0);
    @(posedge clock); #1;
    cycle();
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_valid", rsp_valid, 1'b0);
    reset = 1'b0;

    for (int a = 0; a < (1 << AW); a++) begin
      set_req(1'b1, 1'b1, AW'(a), $urandom(), 4'hF);
      cycle();
    end
    idle(1);

    // Write then read, latency and single write strobe
    base_wr = wr_low;
    set_req(1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF); cycle();
    set_req(1'b1, 1'b0, 10'h005, 32'h0, 4'h0); cycle();
    idle(3);
    chk("raw_basic", last_pop, 32'hDEADBEEF);
    chk("one_write_strobe", 32'(wr_low - base_wr), 32'd1);

    // Byte-merge write
    set_req(1'b1, 1'b1, 10'h3FF, 32'h11223344, 4'hF); cycle();
    set_req(1'b1, 1'b1, 10'h3FF, 32'hAABBCCDD, 4'h5); cycle();
    set_req(1'b1, 1'b0, 10'h3FF, 32'h0, 4'h0); cycle();
    idle(3);
    chk("byte_merge", last_pop, 32'h11BB33DD);

    // Back-to-back write then read of the same address
    set_req(1'b1, 1'b1, 10'h010, 32'hCAFEF00D, 4'hF); cycle();
    set_req(1'b1, 1'b0, 10'h010, 32'h0, 4'h0); cycle();
    idle(3);
    chk("raw_b2b", last_pop, 32'hCAFEF00D);

    // Backpressure: 6 reads with rsp_ready low, then release
    rsp_ready = 1'b0; base_acc = n_acc; base_pop = n_pop; i = 0;
    for (int k = 0; k < 6; k++) begin
      set_req(1'b1, 1'b0, AW'(i), '0, '0); cycle();
      if (last_acc) i++;
    end
    chk("bp_accepted", 32'(n_acc - base_acc), 32'd4);
    chk("bp_ready_low", req_ready, 1'b0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 20 && i < 6; k++) begin
      set_req(1'b1, 1'b0, AW'(i), '0, '0); cycle();
      if (last_acc) i++;
    end
    chk("bp_all_issued", 32'(i), 32'd6);
    idle(5);
    chk("bp_all_returned", 32'(n_pop - base_pop), 32'd6);

    // Full-rate streaming
    base_acc = n_acc;
    for (int k = 0; k < 16; k++) begin
      set_req(1'b1, 1'b0, AW'($urandom()), '0, '0); cycle();
    end
    chk("stream_accepts", 32'(n_acc - base_acc), 32'd16);
    idle(4);

    // Reset with 2 queued and 1 in flight
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ra[k] = AW'($urandom());
      set_req(1'b1, 1'b0, ra[k], '0, '0); cycle();
    end
    req_valid = 1'b0; reset = 1'b1; cycle();
    reset = 1'b0; cycle();
    chk("post_rst_valid", rsp_valid, 1'b0);
    rsp_ready = 1'b1; base_pop = n_pop;
    idle(4);
    chk("no_stale_rsp", 32'(n_pop - base_pop), 32'd0);
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, 1'b0, ra[k], '0, '0); cycle();
    end
    idle(4);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(63) == 0);
      rsp_ready = ($urandom_range(3) != 0);
      set_req(1'($urandom()), 1'($urandom()), AW'($urandom_range(15)), $urandom(), 4'($urandom()));
      cycle();
    end
    reset = 1'b0; rsp_ready = 1'b1;
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
